// File: rtl/decode_xor_scanner_if.sv
// Bus interface for decode_xor_scanner.
// Carries the pushbutton, scan request, memory write port and all result
// outputs. master = driver side (host/testbench), slave = the scanner.
//   pb, start, wr_en, wr_addr, wr_data : master -> slave
//   busy, done, wr_err, mode, led      : slave  -> master
interface decode_xor_scanner_if #(
   parameter int unsigned SEL_W  = 3,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned OH_W   = 1 << SEL_W;
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              pb;
   logic              start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              wr_err;
   logic [1:0]        mode;
   logic [OH_W-1:0]   led;

   modport master (
      output pb, start, wr_en, wr_addr, wr_data,
      input  busy, done, wr_err, mode, led
   );

   modport slave (
      input  pb, start, wr_en, wr_addr, wr_data,
      output busy, done, wr_err, mode, led
   );
endinterface

// File: rtl/decode_xor_scanner.sv
// decode_xor_scanner: scans a small memory, XOR-accumulates the one-hot
// decode of each word's low SEL_W bits, then latches the XOR word, its
// parity and its popcount. A debounced pushbutton cycles the LED display
// between those three results.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : decode_xor_scanner_if.slave (pb, start, write port, busy, done,
//          wr_err, mode, led)
module decode_xor_scanner #(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEB_CYC = 4
) (
   input logic                  clk,
   input logic                  rst,
   decode_xor_scanner_if.slave  bus
);
   localparam int unsigned OH_W   = 1 << SEL_W;
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYC - 1);

   typedef enum logic [1:0] {IDLE, SCAN, PAR, DONE} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [OH_W-1:0]   acc;
   logic [ADDR_W-1:0] index;
   logic [OH_W-1:0]   xor_q;
   logic              par_q;
   logic [OH_W-1:0]   pop_q;
   logic              busy_q, done_q, wr_err_q;
   logic [1:0]        mode_q;
   logic [OH_W-1:0]   led_q;
   logic              sync1, sync2, deb_q;
   logic [CNT_W-1:0]  deb_cnt;

   logic              clr_c, scan_c, par_c, busy_nx_c, done_nx_c;
   logic              wr_ok_c, rise_c;
   logic [SEL_W-1:0]  sel_c;
   logic [OH_W-1:0]   onehot_c, pop_c;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.wr_err = wr_err_q;
   assign bus.mode   = mode_q;
   assign bus.led    = led_q;

   // Writes are refused while a scan is running so the scan sees a frozen memory.
   assign wr_ok_c  = bus.wr_en && !busy_q && (32'(bus.wr_addr) < DEPTH);
   assign sel_c    = mem[index][SEL_W-1:0];
   assign onehot_c = OH_W'(1) << sel_c;

   // Population count of the accumulator.
   always_comb begin
      pop_c = '0;
      for (int unsigned i = 0; i < OH_W; i++) begin
         pop_c = pop_c + OH_W'(acc[i]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (bus.start) state_nx = SCAN;
         SCAN:       if (index == LAST_IDX) state_nx = PAR;
         PAR:        state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // FSM output decode; done only counts once DONE is held, so it lines up
   // with the registered led.
   always_comb begin
      clr_c     = 1'b0;
      scan_c    = 1'b0;
      par_c     = 1'b0;
      busy_nx_c = (state_nx == SCAN) || (state_nx == PAR);
      done_nx_c = (state == DONE) && (state_nx == DONE);
      case (state)
         IDLE, DONE: clr_c  = bus.start;
         SCAN:       scan_c = 1'b1;
         PAR:        par_c  = 1'b1;
         default:    ;
      endcase
   end

   // Memory array, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok_c) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Scan datapath, result latches and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         index    <= '0;
         xor_q    <= '0;
         par_q    <= 1'b0;
         pop_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_nx_c;
         done_q   <= done_nx_c;
         wr_err_q <= bus.wr_en && !wr_ok_c;
         if (clr_c) begin
            acc   <= '0;
            index <= '0;
         end else if (scan_c) begin
            acc   <= acc ^ onehot_c;
            index <= (index == LAST_IDX) ? '0 : index + ADDR_W'(1);
         end
         if (par_c) begin
            xor_q <= acc;
            par_q <= ^acc;
            pop_q <= pop_c;
         end
      end
   end

   // Two-flop synchroniser and debouncer: a new level is taken only after
   // DEB_CYC consecutive samples differ from the accepted level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb_q   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync1 <= bus.pb;
         sync2 <= sync1;
         if (sync2 == deb_q) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CNT_LAST) begin
            deb_q   <= sync2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
         end
      end
   end

   assign rise_c = sync2 && !deb_q && (deb_cnt == CNT_LAST);

   // Display mode and registered LED output; the unreachable mode 3 shows
   // zero and wraps to 0 on the next press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 2'd0;
         led_q  <= '0;
      end else begin
         if (rise_c) mode_q <= (mode_q >= 2'd2) ? 2'd0 : mode_q + 2'd1;
         case (mode_q)
            2'd0:    led_q <= xor_q;
            2'd1:    led_q <= OH_W'(par_q);
            2'd2:    led_q <= pop_q;
            default: led_q <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_decode_xor_scanner.sv
// Scoreboard bench for decode_xor_scanner: stimulus pushes expected scan
// results computed from a shadow memory; a negedge monitor checks each
// done rising edge for latency, led and mode.
module tb_decode_xor_scanner;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned DEB_CYC = 4;

   typedef struct {
      logic [7:0] x;
      logic       p;
      logic [7:0] c;
      int         dcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t       sbq[$];
   exp_t       last_res;
   logic [7:0] m_mem[DEPTH];
   int         m_mode = 0;
   logic       done_prev = 1'b0;

   decode_xor_scanner_if #(.SEL_W(SEL_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   decode_xor_scanner #(
      .SEL_W(SEL_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .DEB_CYC(DEB_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: XOR of decoded one-hots over the whole memory.
   function automatic exp_t model_scan();
      exp_t r;
      logic [7:0] acc = 8'h00;
      for (int i = 0; i < DEPTH; i++) acc ^= (8'h01 << m_mem[i][2:0]);
      r.x = acc;
      r.p = ^acc;
      r.c = 8'($countones(acc));
      r.dcyc = 0;
      return r;
   endfunction

   function automatic logic [7:0] exp_led(input int md, input exp_t r);
      case (md)
         0:       return r.x;
         1:       return {7'd0, r.p};
         2:       return r.c;
         default: return 8'h00;
      endcase
   endfunction

   // Monitor: compares each new result against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.done && !done_prev) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("done_latency", cyc, e.dcyc);
            check("led_at_done", {24'd0, bus.led}, {24'd0, exp_led(m_mode, e)});
            check("mode_at_done", {30'd0, bus.mode}, m_mode);
            last_res = e;
         end
      end
      done_prev = bus.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic exp_err);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
      check("wr_err", {31'd0, bus.wr_err}, {31'd0, exp_err});
      if (!exp_err) m_mem[a] = d;
      tick();
      check("wr_err_one_cycle", {31'd0, bus.wr_err}, 0);
   endtask

   task automatic do_scan();
      exp_t e;
      e = model_scan();
      e.dcyc = cyc + DEPTH + 3;
      sbq.push_back(e);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < DEPTH + 20; i++) begin
         tick();
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", {31'd0, seen}, 1);
      tick();
   endtask

   task automatic press(input int hold);
      bus.pb = 1'b1;
      repeat (hold) tick();
      bus.pb = 1'b0;
      repeat (DEB_CYC + 4) tick();
      if (hold >= DEB_CYC) m_mode = (m_mode + 1) % 3;
      check("mode_after_press", {30'd0, bus.mode}, m_mode);
      check("led_after_press", {24'd0, bus.led}, {24'd0, exp_led(m_mode, last_res)});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'd0, bus.busy}, 0);
      check({tag, "_done"}, {31'd0, bus.done}, 0);
      check({tag, "_wr_err"}, {31'd0, bus.wr_err}, 0);
      check({tag, "_mode"}, {30'd0, bus.mode}, 0);
      check({tag, "_led"}, {24'd0, bus.led}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] vec[DEPTH];
      vec = '{8'd3, 8'd4, 8'd7, 8'd2, 8'd3, 8'd5, 8'd0, 8'd2};
      bus.pb = 1'b0;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      last_res = '{x: 8'h00, p: 1'b0, c: 8'h00, dcyc: 0};

      // Reset state, during and after reset
      #12;
      check_all_zero("in_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check_all_zero("after_reset");

      // Reference vector
      for (int i = 0; i < DEPTH; i++) do_write(3'(i), vec[i], 1'b0);
      do_scan();
      wait_done();
      check("ref_led_B1", {24'd0, bus.led}, 32'hB1);

      // Display cycling with the reference result
      press(DEB_CYC + 2);
      check("ref_mode1_led", {24'd0, bus.led}, 32'h00);
      press(DEB_CYC + 2);
      check("ref_mode2_led", {24'd0, bus.led}, 32'h04);
      press(DEB_CYC + 2);
      check("ref_mode0_led", {24'd0, bus.led}, 32'hB1);

      // Write and start during a scan are both ignored
      do_scan();
      tick();
      do_write(3'd0, 8'h06, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done();
      check("midscan_led_B1", {24'd0, bus.led}, 32'hB1);

      // Short glitch does not change mode
      press(DEB_CYC - 1);
      check("glitch_mode", {30'd0, bus.mode}, 0);

      // Randomised traffic
      for (int it = 0; it < 25; it++) begin
         case ($urandom_range(0, 3))
            0: for (int i = 0; i < DEPTH; i++) do_write(3'(i), 8'($urandom), 1'b0);
            1: repeat ($urandom_range(1, 3)) do_write(3'($urandom_range(0, DEPTH - 1)), 8'($urandom), 1'b0);
            2: press($urandom_range(1, DEB_CYC + 2));
            default: ;
         endcase
         do_scan();
         wait_done();
      end

      // Ensure a non-zero mode then reset mid-scan
      if (m_mode == 0) press(DEB_CYC + 2);
      do_scan();
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check_all_zero("midscan_reset");
      sbq.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_mode = 0;
      last_res = '{x: 8'h00, p: 1'b0, c: 8'h00, dcyc: 0};
      tick();
      tick();
      rst = 1'b0;
      tick();
      do_scan();
      wait_done();
      check("zero_scan_led", {24'd0, bus.led}, 32'h00);
      press(DEB_CYC + 2);
      check("zero_scan_parity", {24'd0, bus.led}, 32'h00);

      check("scoreboard_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
